mem_port_arbiter: RTL and testbench

- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch port and its data (load/store) port.
- Grants one requester at a time and holds the memory request stable until acknowledged. Returns read data plus a one-cycle ready pulse to the winner.
- Stall control derives from the ready pulses: F/D stage stalls until i_ready, M stage stalls until d_ready.
- Includes a starvation guard and a timeout watchdog.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, variable-latency memory between the
// instruction-fetch port and the data (load/store) port.
//   clk, reset (async, active-low)
//   i_req/i_addr -> i_rdata/i_ready      fetch port, req held until the ready pulse
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready   data port, req held until the ready pulse
//   m_req/m_we/m_addr/m_wdata <- m_rdata/m_ack     registered memory request side
//   busy (not idle), err (sticky timeout flag)
module mem_port_arbiter #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT     = 16,
   parameter int D_BURST_MAX = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ready,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ack,
   output logic          busy,
   output logic          err
);
   localparam logic [1:0] IDLE = 2'd0, D_WAIT = 2'd1, I_WAIT = 2'd2, RESP = 2'd3;
   localparam int BW = $clog2(D_BURST_MAX + 1);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [BW-1:0] BURST_MAX = BW'(D_BURST_MAX);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
   logic [1:0]    state;
   logic [BW-1:0] burst_cnt;
   logic [WW-1:0] wait_cnt;
   logic          grant_d;
   logic          is_i;
   // data wins unless it has already taken D_BURST_MAX grants in a row over a pending fetch
   assign grant_d = d_req && !(i_req && burst_cnt == BURST_MAX);
   assign is_i    = state == I_WAIT;
   assign busy    = state != IDLE;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         burst_cnt <= '0;
         wait_cnt  <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_ready   <= 1'b0;
         d_ready   <= 1'b0;
         m_req     <= 1'b0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  m_addr    <= d_addr;
                  m_we      <= d_we;
                  m_wdata   <= d_wdata;
                  m_req     <= 1'b1;
                  wait_cnt  <= '0;
                  state     <= D_WAIT;
                  burst_cnt <= !i_req ? '0 : (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
               end else if (i_req) begin
                  m_addr    <= i_addr;
                  m_we      <= 1'b0;
                  m_req     <= 1'b1;
                  wait_cnt  <= '0;
                  state     <= I_WAIT;
                  burst_cnt <= '0;
               end
            end
            D_WAIT, I_WAIT: begin
               // an ack in the timeout cycle still counts as a normal completion
               if (m_ack || wait_cnt == WAIT_LAST) begin
                  if (is_i) i_rdata <= m_ack ? m_rdata : '0;
                  else if (!m_ack) d_rdata <= '0;
                  else if (!m_we) d_rdata <= m_rdata;
                  if (!m_ack) err <= 1'b1;
                  m_req   <= 1'b0;
                  m_we    <= 1'b0;
                  i_ready <= is_i;
                  d_ready <= !is_i;
                  state   <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               i_ready <= 1'b0;
               d_ready <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a variable-latency memory responder.
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic        i_ready, d_ready, m_req, m_we, m_ack, busy, err;
   logic [31:0] m_rdata = '0;
   logic        resp_ack = 1'b0, stray_ack = 1'b0, ack_en = 1'b0;
   int          ack_delay = 1, ack_cnt = 0;
   logic [31:0] key = 32'hA5A5_0000;
   logic [31:0] last_d = '0;
   int          errors = 0, checks = 0;
   typedef struct {
      logic        is_d;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];
   assign m_ack = resp_ack | stray_ack;
   always #5 clk = ~clk;
   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16), .D_BURST_MAX(2)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack),
      .busy(busy), .err(err)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask
   // memory model: acks ack_delay cycles after first seeing m_req, data = address ^ key
   initial forever begin
      @(negedge clk);
      if (resp_ack) begin
         resp_ack = 1'b0;
         ack_cnt  = 0;
      end else if (m_req && ack_en) begin
         if (ack_cnt == ack_delay) begin
            resp_ack = 1'b1;
            m_rdata  = m_addr ^ key;
            ack_cnt  = 0;
         end else ack_cnt++;
      end else ack_cnt = 0;
   end
   // ready monitor: every ready pulse must match the oldest expected completion
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (i_ready || d_ready) begin
            if (sb.size() == 0) chk("spurious_ready", 32'({i_ready, d_ready}), 32'd0);
            else begin
               e = sb.pop_front();
               chk("ready_port", 32'({i_ready, d_ready}), e.is_d ? 32'd1 : 32'd2);
               chk("ready_rdata", e.is_d ? d_rdata : i_rdata, e.data);
            end
         end
      end
   end
   task automatic txn(input logic is_d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int delay, input logic to, output int lat, output int reqc);
      exp_t e;
      logic rdy;
      @(negedge clk);
      ack_delay = delay;
      ack_en    = !to;
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      e.is_d = is_d;
      e.data = to ? 32'd0 : (is_d && we) ? last_d : addr ^ key;
      if (is_d) last_d = e.data;
      sb.push_back(e);
      lat  = 0;
      reqc = 0;
      rdy  = 1'b0;
      while (lat < 100 && !rdy) begin
         @(negedge clk);
         lat++;
         if (m_req) begin
            reqc++;
            chk("m_addr_held", m_addr, addr);
            chk("m_we_held", 32'(m_we), 32'(is_d && we));
            if (is_d) chk("m_wdata_held", m_wdata, wdata);
         end
         rdy = is_d ? d_ready : i_ready;
      end
      if (!rdy) chk("ready_never_seen", 32'(rdy), 32'd1);
      i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   initial begin
      int lat, rc, n;
      repeat (4) begin
         @(negedge clk);
         i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
         i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; stray_ack = 1'($urandom);
         #1;
         chk("rst_i_rdata", i_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
         chk("rst_m_addr", m_addr, 0);   chk("rst_m_wdata", m_wdata, 0);
         chk("rst_m_req", 32'(m_req), 0); chk("rst_m_we", 32'(m_we), 0);
         chk("rst_i_ready", 32'(i_ready), 0); chk("rst_d_ready", 32'(d_ready), 0);
         chk("rst_busy", 32'(busy), 0);  chk("rst_err", 32'(err), 0);
      end
      @(negedge clk);
      i_req = 0; d_req = 0; d_we = 0; stray_ack = 0;
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_busy", 32'(busy), 0);
         chk("idle_m_req", 32'(m_req), 0);
      end
      key = 32'h2002_0045;
      txn(1'b0, 1'b0, 32'h40, 32'h0, 3, 1'b0, lat, rc);
      chk("fetch_latency", 32'(lat), 5);
      chk("fetch_req_cycles", 32'(rc), 4);
      chk("fetch_rdata", i_rdata, 32'h2002_0005);
      @(negedge clk);
      chk("fetch_ready_one_cycle", 32'(i_ready), 0);
      chk("fetch_back_idle", 32'(busy), 0);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      chk("stray_ack_busy", 32'(busy), 0);
      chk("stray_ack_i_ready", 32'(i_ready), 0);
      chk("stray_ack_i_rdata", i_rdata, 32'h2002_0005);
      key = 32'hA5A5_0000;
      txn(1'b1, 1'b0, 32'h84, 32'h0, 1, 1'b0, lat, rc);
      chk("load_rdata", d_rdata, 32'h84 ^ key);
      txn(1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 2, 1'b0, lat, rc);
      chk("store_req_cycles", 32'(rc), 3);
      chk("store_keeps_d_rdata", d_rdata, 32'h84 ^ key);
      @(negedge clk);
      ack_en = 1'b1; ack_delay = 1;
      for (int k = 0; k < 6; k++) sb.push_back('{is_d: (k % 3 != 2), data: (k % 3 != 2) ? 32'h200 ^ key : 32'h100 ^ key});
      last_d = 32'h200 ^ key;
      i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      i_req = 1'b0; d_req = 1'b0;
      chk("contention_drained", 32'(sb.size()), 0);
      repeat (2) @(negedge clk);
      txn(1'b1, 1'b0, 32'h300, 32'h0, 0, 1'b1, lat, rc);
      chk("timeout_req_cycles", 32'(rc), 16);
      chk("timeout_latency", 32'(lat), 17);
      chk("timeout_err", 32'(err), 1);
      chk("timeout_d_rdata", d_rdata, 0);
      txn(1'b0, 1'b0, 32'h140, 32'h0, 2, 1'b0, lat, rc);
      chk("post_timeout_fetch", i_rdata, 32'h140 ^ key);
      chk("err_sticky", 32'(err), 1);
      @(negedge clk);
      ack_en = 1'b0;
      i_addr = 32'h500; i_req = 1'b1;
      n = 0;
      while (!m_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("midwait_granted", 32'(m_req), 1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midwait_m_req_drop", 32'(m_req), 0);
      chk("midwait_busy", 32'(busy), 0);
      chk("midwait_err_cleared", 32'(err), 0);
      i_req = 1'b0;
      last_d = '0;
      repeat (2) begin
         @(negedge clk);
         chk("midwait_no_ready", 32'(i_ready), 0);
      end
      reset = 1'b1;
      txn(1'b0, 1'b0, 32'h600, 32'h0, 1, 1'b0, lat, rc);
      chk("after_reset_fetch_lat", 32'(lat), 3);
      chk("after_reset_fetch", i_rdata, 32'h600 ^ key);
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
